flash_read_responder: RTL

Avalon-MM read-only slave that models the flash controller on the far side of the player's `flsh_*` read-master port. It accepts one word read at a time, stalls the master with a programmable number of `flsh_waitrequest` cycles, and returns a deterministic address-derived word after a programmable latency, pulsed with `flsh_readdatavalid`. It stands in for the flash IP in simulation and in bring-up builds, and drives the audio path with known data.

---
 rtl/flash_read_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/flash_read_responder.sv
// flash_read_responder
//   Avalon-MM read-only slave standing in for the flash controller behind the
//   player's flsh_* read master. Accepts one word read at a time, stalls with
//   WAIT_CYCLES waitrequest cycles, and returns {addr[15:0], ~addr[15:0]}
//   (zero above MAX_ADDR, per-lane masked by byteenable) LATENCY cycles after
//   the accept, strobed by flsh_readdatavalid.
//
// Ports
//   clk                 in   clock, rising edge
//   reset_n             in   asynchronous active-low reset
//   flsh_read           in   read request
//   flsh_address        in   word address [ADDR_W]
//   flsh_byteenable     in   byte lanes requested [4]
//   flsh_waitrequest    out  high = request not accepted this cycle
//   flsh_readdata       out  returned word, registered, held between strobes
//   flsh_readdatavalid  out  single-cycle data strobe
//   rd_count            out  completed responses, wraps modulo 2^16
module flash_read_responder #(
   parameter int unsigned        ADDR_W      = 23,
   parameter int unsigned        WAIT_CYCLES = 1,
   parameter int unsigned        LATENCY     = 3,
   parameter logic [ADDR_W-1:0]  MAX_ADDR    = 23'h07FFFF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flsh_read,
   input  logic [ADDR_W-1:0] flsh_address,
   input  logic [3:0]        flsh_byteenable,
   output logic              flsh_waitrequest,
   output logic [31:0]       flsh_readdata,
   output logic              flsh_readdatavalid,
   output logic [15:0]       rd_count
);

   typedef enum logic [1:0] {StIdle, StStall, StBusy} state_e;

   localparam logic [7:0] StallLoad = 8'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
   localparam logic [7:0] LatLoad   = 8'(LATENCY - 1);

   state_e            state_q, state_d;
   logic [7:0]        stall_q, stall_d;
   logic [7:0]        lat_q, lat_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       data_q, data_d;
   logic              valid_q, valid_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              wait_req;
   logic              accept;

   function automatic logic [31:0] make_word(input logic [ADDR_W-1:0] a, input logic [3:0] be);
      logic [31:0] w;
      w = {a[15:0], ~a[15:0]};
      if (a > MAX_ADDR) w = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (!be[i]) w[8*i +: 8] = 8'h00;
      end
      return w;
   endfunction

   // Waitrequest depends on state only; no path from flsh_read.
   always_comb begin
      wait_req = 1'b1;
      unique case (state_q)
         StIdle:  wait_req = (WAIT_CYCLES != 0);
         StStall: wait_req = (stall_q != 8'd0);
         default: wait_req = 1'b1;
      endcase
   end

   assign accept = flsh_read && !wait_req;

   always_comb begin
      state_d = state_q;
      stall_d = stall_q;
      lat_d   = lat_q;
      addr_d  = addr_q;
      be_d    = be_q;
      data_d  = data_q;
      valid_d = 1'b0;
      cnt_d   = cnt_q;

      if (accept) begin
         addr_d = flsh_address;
         be_d   = flsh_byteenable;
         lat_d  = LatLoad;
         if (LATENCY == 1) begin
            // Counter is loaded with 0, so the response fires on the accept edge.
            valid_d = 1'b1;
            data_d  = make_word(flsh_address, flsh_byteenable);
            cnt_d   = cnt_q + 16'd1;
            state_d = StIdle;
         end else begin
            state_d = StBusy;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (flsh_read) begin
                  state_d = StStall;
                  stall_d = StallLoad;
               end
            end
            StStall: begin
               if (!flsh_read) state_d = StIdle;
               else            stall_d = stall_q - 8'd1;
            end
            StBusy: begin
               // The edge that takes the counter to 0 also issues the strobe,
               // so the strobe cycle is already IDLE.
               lat_d = lat_q - 8'd1;
               if (lat_q == 8'd1) begin
                  valid_d = 1'b1;
                  data_d  = make_word(addr_q, be_q);
                  cnt_d   = cnt_q + 16'd1;
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         stall_q <= 8'd0;
         lat_q   <= 8'd0;
         addr_q  <= '0;
         be_q    <= 4'h0;
         data_q  <= 32'h0;
         valid_q <= 1'b0;
         cnt_q   <= 16'h0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
         lat_q   <= lat_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign flsh_waitrequest   = wait_req;
   assign flsh_readdata      = data_q;
   assign flsh_readdatavalid = valid_q;
   assign rd_count           = cnt_q;

endmodule
